reg_watch_monitor: RTL and testbench
====================================

// Module: reg_watch_monitor
// PURPOSE
//  Synthesizable successor to the directed "wait for register = value, else time out" check used in the
//  Riscv151 assembly benches. Snoops the register-file writeback port; NUM_CH programmable watch channels
//  each match (reg index, masked value). Ordered or any-order completion, cycle timeout, sticky pass/fail.
//  Sits beside CPU.rf; drives a status CSR/LED path and bench $finish logic.
// PARAMETERS
//  NUM_CH     4      number of watch channels (1..8)
//  XLEN       32     writeback data width
//  TMO_W      16     timeout counter width
// PORTS
//  clk          in   1               CPU clock
//  rst          in   1               asynchronous, active-low reset
//  wb_en        in   1               regfile write strobe this cycle
//  wb_addr      in   5               regfile write index
//  wb_data      in   XLEN            regfile write data
//  cfg_we       in   1               write channel cfg_ch (ignored unless state IDLE)
//  cfg_ch       in   $clog2(NUM_CH)  channel select
//  cfg_reg      in   5               watched register index
//  cfg_val      in   XLEN            expected value
//  cfg_mask     in   XLEN            compare mask (1 = bit compared)
//  cfg_en       in   1               channel enabled
//  ordered      in   1               1: channels must hit in index order; sampled at arm
//  tmo_limit    in   TMO_W           timeout cycles; sampled at arm; 0 = no timeout
//  arm          in   1               start monitoring (IDLE/DONE -> RUN)
//  clear        in   1               return to IDLE, clears hits/status (config kept)
//  ch_hit       out  NUM_CH          sticky per-channel hit flags
//  busy         out  1               state RUN
//  done         out  1               state PASS or FAIL
//  pass         out  1               all enabled channels hit
//  timeout      out  1               FAIL due to tmo_limit reached
//  cycles       out  TMO_W           cycles elapsed since arm (saturating)
// BEHAVIOUR
//  Reset: state IDLE; ch_hit, busy, done, pass, timeout, cycles = 0; all channel cfg cleared (cfg_en=0).
//  FSM IDLE -arm-> RUN; RUN -all enabled hit-> PASS; RUN -cycles==tmo_limit (limit!=0)-> FAIL;
//   PASS/FAIL -arm-> RUN (hits cleared, cycles=0); any state -clear-> IDLE. clear beats arm.
//  Match (RUN only): wb_en && wb_addr!=0 && wb_addr==cfg_reg && ((wb_data^cfg_val)&cfg_mask)==0.
//   Writes to x0 never match. Registered: ch_hit set the cycle after the matching write.
//  Ordered mode: channel k eligible only if all enabled lower channels already hit (registered flags);
//   disabled channels skipped. A match on an ineligible channel is ignored, not remembered.
//  Any-order mode: every enabled channel eligible; one write may hit several channels in one cycle.
//  ch_hit sticky until arm/clear; later non-matching writes to that register do not clear it.
//  PASS entered the cycle after the last hit flag sets (2 cycles after the write); done=pass=1, busy=0.
//  Zero enabled channels at arm -> PASS one cycle later.
//  cycles: 0 on arm, +1 each RUN cycle, saturates at all-ones, frozen in PASS/FAIL.
//  Timeout: FAIL when cycles==tmo_limit at a clock edge in RUN; if final hit and timeout same edge, PASS wins.
//  arm while RUN: restart (hits cleared, cycles=0, ordered/tmo_limit resampled).
//  Async reset mid-RUN: immediate return to reset values, including channel config.
//  cfg_we outside IDLE ignored; cfg_ch >= NUM_CH ignored.
// TESTING
//  T1 ordered: ch0={x20,1,mask all}, ch1={x1,300}; write x1=300 then x20=1 -> ch1 not hit; write x1=300 -> ch_hit=2'b11, pass.
//  T2 any-order: ch0={x3,32'h4000_000c}, ch1={x20,2}; x20=2 then x3 -> pass=1 two cycles after the x3 write.
//  T3 mask: ch0={x5,32'h0000_00AB,mask 32'hFF}; write x5=32'h1234_56AB -> hit; x5=32'h1234_56AC -> no hit.
//  T4 timeout: tmo_limit=1000, no matching write -> done=1, timeout=1, pass=0, cycles=1000 frozen.
//  T5 x0 / simultaneous: ch0={x0,0} never hits; last hit on the same edge cycles reaches tmo_limit -> pass=1, timeout=0.
//  T6 reset: assert rst low mid-RUN with ch_hit=01 -> all outputs 0 immediately, cfg_en cleared; re-arm -> pass (no channels).

Source files
------------

// File: rtl/reg_watch_monitor.sv
// reg_watch_monitor: snoops the register-file writeback port and waits for a
// programmable set of (register, masked value) matches. Matches may be ordered
// or in any order. An optional cycle timeout ends the wait, and pass/fail are sticky.
module reg_watch_monitor #(
  parameter int NUM_CH = 4,
  parameter int XLEN   = 32,
  parameter int TMO_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [4:0]        cfg_reg,
  input  logic [XLEN-1:0]   cfg_val,
  input  logic [XLEN-1:0]   cfg_mask,
  input  logic              cfg_en,
  input  logic              ordered,
  input  logic [TMO_W-1:0]  tmo_limit,
  input  logic              arm,
  input  logic              clear,
  output logic [NUM_CH-1:0] ch_hit,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [TMO_W-1:0]  cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Per-channel watch configuration
  logic [4:0]        r_cfg_reg  [NUM_CH];
  logic [XLEN-1:0]   r_cfg_val  [NUM_CH];
  logic [XLEN-1:0]   r_cfg_mask [NUM_CH];
  logic [NUM_CH-1:0] r_cfg_en;

  // Run-time state captured at arm, plus progress
  logic              r_ordered;
  logic [TMO_W-1:0]  r_tmo_limit;
  logic [NUM_CH-1:0] r_hit;
  logic [TMO_W-1:0]  r_cycles;

  logic [NUM_CH-1:0] w_match;
  logic [NUM_CH-1:0] w_elig;
  logic              w_all_hit;
  logic              w_tmo_hit;

  // Channel configuration: writable only while idle, and only for channels that exist
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_en <= '0;
      // NOTE: the config arrays are a few flops, not RAM, so resetting them is cheap;
      // it guarantees that no stale channel is armed after reset.
      for (int k = 0; k < NUM_CH; k++) begin
        r_cfg_reg[k]  <= '0;
        r_cfg_val[k]  <= '0;
        r_cfg_mask[k] <= '0;
      end
    end else if (cfg_we && (r_state == S_IDLE) && (int'(cfg_ch) < NUM_CH)) begin
      r_cfg_reg[cfg_ch]  <= cfg_reg;
      r_cfg_val[cfg_ch]  <= cfg_val;
      r_cfg_mask[cfg_ch] <= cfg_mask;
      r_cfg_en[cfg_ch]   <= cfg_en;
    end
  end

  // Raw per-channel match against the current writeback. Writes to x0 never count.
  always_comb begin
    // NOTE: assign the default before the loop so that every path drives every bit (no latch).
    w_match = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_match[k] = (r_state == S_RUN) && wb_en && (wb_addr != 5'd0) && r_cfg_en[k] &&
                   (wb_addr == r_cfg_reg[k]) &&
                   (((wb_data ^ r_cfg_val[k]) & r_cfg_mask[k]) == '0);
    end
  end

  // Eligibility: in ordered mode a channel waits until every enabled lower channel has hit
  always_comb begin
    logic prior_ok;
    prior_ok = 1'b1;
    w_elig   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_elig[k] = !r_ordered || prior_ok;
      prior_ok  = prior_ok && (!r_cfg_en[k] || r_hit[k]);
    end
  end

  assign w_all_hit = &(r_hit | ~r_cfg_en);
  assign w_tmo_hit = (r_tmo_limit != '0) && (r_cycles == r_tmo_limit);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clear beats arm, and a completed set beats timeout on the same edge
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else if (arm) begin
      w_state_nxt = S_RUN;
    end else if (r_state == S_RUN) begin
      if (w_all_hit) begin
        w_state_nxt = S_PASS;
      end else if (w_tmo_hit) begin
        w_state_nxt = S_FAIL;
      end
    end
  end

  // Hit flags, cycle counter and values sampled at arm
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ordered   <= 1'b0;
      r_tmo_limit <= '0;
      r_hit       <= '0;
      r_cycles    <= '0;
    end else if (clear) begin
      r_hit    <= '0;
      r_cycles <= '0;
    end else if (arm) begin
      r_ordered   <= ordered;
      r_tmo_limit <= tmo_limit;
      r_hit       <= '0;
      r_cycles    <= '0;
    end else if (r_state == S_RUN) begin
      r_hit <= r_hit | (w_match & w_elig);
      if ((w_state_nxt == S_RUN) && (r_cycles != '1)) begin
        r_cycles <= r_cycles + 1'b1;
      end
    end
  end

  assign ch_hit  = r_hit;
  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass    = (r_state == S_PASS);
  assign timeout = (r_state == S_FAIL);
  assign cycles  = r_cycles;

endmodule

// File: tb/tb_reg_watch_monitor.sv
// Scoreboard bench for reg_watch_monitor: the driver steps a behavioural model and
// queues the expected outputs. A monitor on the falling edge compares them with the DUT.
module tb_reg_watch_monitor;
  localparam int NUM_CH = 4;
  localparam int XLEN   = 32;
  localparam int TMO_W  = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [4:0]        cfg_reg;
  logic [XLEN-1:0]   cfg_val;
  logic [XLEN-1:0]   cfg_mask;
  logic              cfg_en;
  logic              ordered;
  logic [TMO_W-1:0]  tmo_limit;
  logic              arm;
  logic              clear;
  logic [NUM_CH-1:0] ch_hit;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [TMO_W-1:0]  cycles;

  always #5 clk = ~clk;

  reg_watch_monitor #(.NUM_CH(NUM_CH), .XLEN(XLEN), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reg(cfg_reg), .cfg_val(cfg_val),
    .cfg_mask(cfg_mask), .cfg_en(cfg_en), .ordered(ordered), .tmo_limit(tmo_limit),
    .arm(arm), .clear(clear), .ch_hit(ch_hit), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .cycles(cycles)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] hit;
    logic              busy;
    logic              done;
    logic              pass;
    logic              tmo;
    logic [TMO_W-1:0]  cyc;
  } snap_t;

  typedef struct {
    bit        rst;
    bit        wb_en;
    bit [4:0]  wb_addr;
    bit [31:0] wb_data;
    bit        cfg_we;
    bit [1:0]  cfg_ch;
    bit [4:0]  cfg_reg;
    bit [31:0] cfg_val;
    bit [31:0] cfg_mask;
    bit        cfg_en;
    bit        ordered;
    bit [15:0] tmo_limit;
    bit        arm;
    bit        clear;
  } stim_t;

  snap_t dut_now;
  assign dut_now = {ch_hit, busy, done, pass, timeout, cycles};

  stim_t cur;
  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string phase_name = "reset";

  // Reference model: phase, per-channel config, hit set, cycle count
  typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mphase_t;
  mphase_t   m_phase;
  bit [4:0]  m_reg  [NUM_CH];
  bit [31:0] m_val  [NUM_CH];
  bit [31:0] m_mask [NUM_CH];
  bit        m_en   [NUM_CH];
  bit        m_hit  [NUM_CH];
  int        m_cycles;
  bit        m_ordered;
  int        m_tmo;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_phase   = M_IDLE;
    m_cycles  = 0;
    m_ordered = 1'b0;
    m_tmo     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_reg[k] = '0; m_val[k] = '0; m_mask[k] = '0; m_en[k] = 1'b0; m_hit[k] = 1'b0;
    end
  endfunction

  // Outcome of one clock edge given the inputs presented before it
  function automatic void model_step(stim_t s);
    bit all_done;
    bit tmo_due;
    int first_open;
    bit hits [NUM_CH];
    if (!s.rst) begin
      model_reset();
      return;
    end
    all_done   = 1'b1;
    first_open = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_en[k] && !m_hit[k]) begin
        all_done = 1'b0;
        if (first_open < 0) first_open = k;
      end
    end
    tmo_due = (m_tmo != 0) && (m_cycles == m_tmo);
    hits = m_hit;
    if (m_phase == M_RUN && s.wb_en && s.wb_addr != 5'd0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_en[k] && !m_hit[k] && s.wb_addr == m_reg[k] &&
            (s.wb_data & m_mask[k]) == (m_val[k] & m_mask[k]) &&
            (!m_ordered || k == first_open))
          hits[k] = 1'b1;
      end
    end
    if (m_phase == M_IDLE && s.cfg_we && int'(s.cfg_ch) < NUM_CH) begin
      m_reg[s.cfg_ch]  = s.cfg_reg;
      m_val[s.cfg_ch]  = s.cfg_val;
      m_mask[s.cfg_ch] = s.cfg_mask;
      m_en[s.cfg_ch]   = s.cfg_en;
    end
    if (s.clear) begin
      m_phase = M_IDLE;
      m_cycles = 0;
      for (int k = 0; k < NUM_CH; k++) m_hit[k] = 1'b0;
    end else if (s.arm) begin
      m_phase   = M_RUN;
      m_cycles  = 0;
      m_ordered = s.ordered;
      m_tmo     = int'(s.tmo_limit);
      for (int k = 0; k < NUM_CH; k++) m_hit[k] = 1'b0;
    end else if (m_phase == M_RUN) begin
      m_hit = hits;
      if (all_done) m_phase = M_PASS;
      else if (tmo_due) m_phase = M_FAIL;
      else if (m_cycles < 65535) m_cycles++;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    for (int k = 0; k < NUM_CH; k++) s.hit[k] = m_hit[k];
    s.busy = (m_phase == M_RUN);
    s.done = (m_phase == M_PASS) || (m_phase == M_FAIL);
    s.pass = (m_phase == M_PASS);
    s.tmo  = (m_phase == M_FAIL);
    s.cyc  = 16'(m_cycles);
    return s;
  endfunction

  // One driven cycle: apply inputs, step the model, queue the expected outputs
  task automatic tick();
    @(negedge clk);
    #1;
    rst = cur.rst; wb_en = cur.wb_en; wb_addr = cur.wb_addr; wb_data = cur.wb_data;
    cfg_we = cur.cfg_we; cfg_ch = cur.cfg_ch; cfg_reg = cur.cfg_reg; cfg_val = cur.cfg_val;
    cfg_mask = cur.cfg_mask; cfg_en = cur.cfg_en; ordered = cur.ordered;
    tmo_limit = cur.tmo_limit; arm = cur.arm; clear = cur.clear;
    model_step(cur);
    exp_q.push_back(model_snap());
    cur.wb_en = 1'b0; cur.cfg_we = 1'b0; cur.arm = 1'b0; cur.clear = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  // Look at the state just after the edge of the previous tick
  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(int ch, int r, logic [31:0] v, logic [31:0] m, bit en);
    cur.cfg_we = 1'b1; cur.cfg_ch = 2'(ch); cur.cfg_reg = 5'(r);
    cur.cfg_val = v; cur.cfg_mask = m; cur.cfg_en = en;
    tick();
  endtask

  task automatic wb(int a, logic [31:0] d);
    cur.wb_en = 1'b1; cur.wb_addr = 5'(a); cur.wb_data = d;
    tick();
  endtask

  task automatic do_arm(bit ord, int lim);
    cur.arm = 1'b1; cur.ordered = ord; cur.tmo_limit = 16'(lim);
    tick();
  endtask

  task automatic setup(string name);
    phase_name = name;
    cur.clear = 1'b1;
    tick();
    for (int k = 0; k < NUM_CH; k++) cfg_wr(k, 0, 32'h0, 32'h0, 1'b0);
  endtask

  // Monitor: one queued expectation per driven cycle
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({phase_name, " outputs"}, 64'(dut_now), 64'(e));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    rst = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_reg = '0; cfg_val = '0; cfg_mask = '0; cfg_en = 1'b0; ordered = 1'b0;
    tmo_limit = '0; arm = 1'b0; clear = 1'b0;
    cur.rst = 1'b0;
    model_reset();
    idle(2);
    cur.rst = 1'b1;
    idle(1);
    peek();
    check("reset state", 64'(dut_now), 64'(0));

    // T1: ordered, the early ch1 match is ignored
    setup("T1 ordered");
    cfg_wr(0, 20, 32'd1, 32'hFFFF_FFFF, 1'b1);
    cfg_wr(1, 1, 32'd300, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b1, 0);
    wb(1, 32'd300);
    wb(20, 32'd1);
    peek();
    check("T1 ch_hit after x20", 64'(ch_hit), 64'(4'b0001));
    wb(1, 32'd300);
    peek();
    check("T1 ch_hit final", 64'(ch_hit), 64'(4'b0011));
    idle(1);
    peek();
    check("T1 pass", 64'(pass), 64'(1));

    // T2: any order, pass two cycles after the last write
    setup("T2 any-order");
    cfg_wr(0, 3, 32'h4000_000c, 32'hFFFF_FFFF, 1'b1);
    cfg_wr(1, 20, 32'd2, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b0, 0);
    wb(20, 32'd2);
    wb(3, 32'h4000_000c);
    peek();
    check("T2 hits, not yet pass", 64'({ch_hit, pass}), 64'({4'b0011, 1'b0}));
    idle(1);
    peek();
    check("T2 pass", 64'({done, pass}), 64'(2'b11));

    // T3: masked compare
    setup("T3 mask");
    cfg_wr(0, 5, 32'h0000_00AB, 32'h0000_00FF, 1'b1);
    do_arm(1'b0, 0);
    wb(5, 32'h1234_56AC);
    peek();
    check("T3 no hit on AC", 64'(ch_hit), 64'(0));
    wb(5, 32'h1234_56AB);
    peek();
    check("T3 hit on AB", 64'(ch_hit), 64'(4'b0001));
    idle(1);

    // T4: timeout with the counter frozen at the limit
    setup("T4 timeout");
    cfg_wr(0, 9, 32'h77, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b0, 1000);
    idle(1005);
    peek();
    check("T4 status", 64'({busy, done, pass, timeout}), 64'(4'b0101));
    check("T4 cycles", 64'(cycles), 64'(1000));

    // T5: x0 never matches
    setup("T5 x0");
    cfg_wr(0, 0, 32'h0, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b0, 20);
    repeat (25) wb(0, 32'h0);
    peek();
    check("T5 x0 no hit, timeout", 64'({ch_hit, timeout}), 64'({4'b0000, 1'b1}));

    // T5: final hit lands on the edge where cycles reaches the limit, so pass wins
    setup("T5 simultaneous");
    cfg_wr(0, 7, 32'd5, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b0, 10);
    idle(9);
    wb(7, 32'd5);
    peek();
    check("T5 hit at limit", 64'({ch_hit, cycles}), 64'({4'b0001, 16'd10}));
    idle(1);
    peek();
    check("T5 pass wins", 64'({pass, timeout}), 64'(2'b10));

    // One cycle later the timeout is decided first
    setup("T5 late");
    cfg_wr(0, 7, 32'd5, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b0, 10);
    idle(10);
    wb(7, 32'd5);
    peek();
    check("T5 late fails", 64'({pass, timeout}), 64'(2'b01));

    // T6: async reset mid-run clears status and config
    setup("T6 reset");
    cfg_wr(0, 10, 32'd1, 32'hFFFF_FFFF, 1'b1);
    cfg_wr(1, 11, 32'd2, 32'hFFFF_FFFF, 1'b1);
    do_arm(1'b0, 0);
    wb(10, 32'd1);
    idle(2);
    peek();
    check("T6 before reset", 64'({ch_hit, busy}), 64'({4'b0001, 1'b1}));
    cur.rst = 1'b0;
    tick();
    #1;
    check("T6 async reset", 64'(dut_now), 64'(0));
    cur.rst = 1'b1;
    tick();
    do_arm(1'b0, 0);
    peek();
    check("T6 rearm busy", 64'(busy), 64'(1));
    idle(1);
    peek();
    check("T6 empty set passes", 64'({pass, ch_hit}), 64'({1'b1, 4'b0000}));

    // Randomized traffic against the model
    phase_name = "random";
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(99));
      if (r < 3) begin
        cur.clear = 1'b1;
      end else if (r < 7) begin
        cur.arm = 1'b1;
        cur.ordered = 1'($urandom_range(1));
        cur.tmo_limit = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom_range(60, 5));
      end
      if ($urandom_range(3) == 0) begin
        cur.cfg_we = 1'b1;
        cur.cfg_ch = 2'($urandom_range(3));
        cur.cfg_reg = 5'($urandom_range(7));
        cur.cfg_val = $urandom();
        case ($urandom_range(2))
          0:       cur.cfg_mask = 32'hFFFF_FFFF;
          1:       cur.cfg_mask = 32'h0000_00FF;
          default: cur.cfg_mask = $urandom();
        endcase
        cur.cfg_en = ($urandom_range(3) != 0);
      end
      if ($urandom_range(9) < 6) begin
        k = int'($urandom_range(NUM_CH - 1));
        cur.wb_en = 1'b1;
        if (m_en[k] && $urandom_range(2) != 0) begin
          cur.wb_addr = m_reg[k];
          cur.wb_data = ($urandom_range(4) == 0) ? (m_val[k] ^ $urandom())
                                                 : (m_val[k] ^ ($urandom() & ~m_mask[k]));
        end else begin
          cur.wb_addr = 5'($urandom_range(7));
          cur.wb_data = $urandom();
        end
      end
      tick();
    end
    idle(1);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
